bios_rom_bus_slave: RTL and testbench

- Bus-side read controller that sits directly upstream of the BIOS ROM.
- Decodes the BIOS address window on the shared system bus and drives the ROM word address.
- Registers the ROM data and returns it to the bus master as single or burst read transfers.
- Rejects writes with a bus error. All bus outputs are zero when the slave is not driving them, as the bus is wired-OR.

---
 rtl/bios_bus_pkg.sv | 31 +++
 rtl/bus_input_register.sv | 24 ++
 rtl/bios_rom_bus_slave.sv | 146 ++++++++++++++
 tb/tb_bios_rom_bus_slave.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bios_bus_pkg.sv
// Shared definitions for the BIOS ROM bus slave: FSM encoding, window constants,
// the registered bus input bundle and the ROM byte-order helper.
package bios_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StFlush,
        StEnd,
        StError
    } bus_state_e;

    localparam logic [31:0] BIOS_BASE_ADDRESS = 32'hF000_0000;
    localparam int unsigned BIOS_WINDOW_BITS  = 13;

    typedef struct packed {
        logic        begin_txn;
        logic [31:0] address;
        logic        read_not_write;
        logic [7:0]  burst_size;
        logic [3:0]  byte_enables;
        logic        end_txn;
        logic        bus_error;
    } bus_in_t;

    // ROM images are little-endian; the CPU expects big-endian words.
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/bus_input_register.sv
// Single-stage register for the shared-bus input bundle; reusable by any slave
// that wants its bus inputs sampled once before decoding.
module bus_input_register
    import bios_bus_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  bus_in_t i_bus,
    output bus_in_t o_bus
);

    bus_in_t r_bus;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bus <= '0;
        end else begin
            r_bus <= i_bus;
        end
    end

    assign o_bus = r_bus;

endmodule

// File: rtl/bios_rom_bus_slave.sv
// Read-only bus slave in front of the BIOS ROM: decodes the window, streams single
// or burst reads one word per cycle, and answers writes with a bus error.
module bios_rom_bus_slave
    import bios_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = BIOS_BASE_ADDRESS,
    parameter int unsigned ROM_ADDR_WIDTH = 11,
    parameter bit          SWAP_BYTES     = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      beginTransactionIn,
    input  logic [31:0]               addressDataIn,
    input  logic                      readNotWriteIn,
    input  logic [7:0]                burstSizeIn,
    input  logic [3:0]                byteEnablesIn,
    input  logic                      endTransactionIn,
    input  logic                      busErrorIn,
    output logic [31:0]               addressDataOut,
    output logic                      dataValidOut,
    output logic                      endTransactionOut,
    output logic                      busErrorOut,
    output logic                      busyOut,
    output logic [ROM_ADDR_WIDTH-1:0] romAddress,
    input  logic [31:0]               romData
);

    bus_in_t w_bus_raw;
    bus_in_t w_bus;

    assign w_bus_raw = '{
        begin_txn:      beginTransactionIn,
        address:        addressDataIn,
        read_not_write: readNotWriteIn,
        burst_size:     burstSizeIn,
        byte_enables:   byteEnablesIn,
        end_txn:        endTransactionIn,
        bus_error:      busErrorIn
    };

    bus_input_register u_bus_input_register (
        .clock (clock),
        .reset (reset),
        .i_bus (w_bus_raw),
        .o_bus (w_bus)
    );

    bus_state_e                r_state;
    logic [ROM_ADDR_WIDTH-1:0] r_word_ptr;
    logic [7:0]                r_remaining;
    logic [31:0]               r_data;
    logic                      r_valid;
    logic                      r_end;
    logic                      r_err;

    logic                      w_hit;
    logic                      w_read_hit;
    logic                      w_write_hit;
    logic                      w_abort;
    logic [ROM_ADDR_WIDTH-1:0] w_addr_word;
    logic [31:0]               w_rom_word;
    logic                      w_unused;

    assign w_hit       = w_bus.begin_txn &&
                         (w_bus.address[31:BIOS_WINDOW_BITS] == BASE_ADDRESS[31:BIOS_WINDOW_BITS]);
    assign w_read_hit  = w_hit && w_bus.read_not_write;
    assign w_write_hit = w_hit && !w_bus.read_not_write;
    assign w_abort     = w_bus.end_txn || w_bus.bus_error;
    assign w_addr_word = w_bus.address[ROM_ADDR_WIDTH+1:2];
    assign w_rom_word  = SWAP_BYTES ? byte_swap(romData) : romData;
    assign w_unused    = ^{w_bus.byte_enables, w_bus.address[1:0]};

    // The first word is issued straight from IDLE so the ROM sees its address one
    // cycle after beginTransactionIn; later words come from the running pointer.
    always_comb begin
        romAddress = r_word_ptr;
        if (r_state == StIdle) begin
            romAddress = w_read_hit ? w_addr_word : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_word_ptr  <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_end       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Wired-OR bus: everything returns to zero unless explicitly driven.
            r_data  <= '0;
            r_valid <= 1'b0;
            r_end   <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_read_hit) begin
                        r_data      <= w_rom_word;
                        r_valid     <= 1'b1;
                        r_word_ptr  <= w_addr_word + ROM_ADDR_WIDTH'(1);
                        r_remaining <= w_bus.burst_size - 8'd1;
                        r_state     <= (w_bus.burst_size == 8'd0) ? StFlush : StRead;
                    end else if (w_write_hit) begin
                        r_end   <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= StError;
                    end
                end
                StRead: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                    end else begin
                        r_data     <= w_rom_word;
                        r_valid    <= 1'b1;
                        r_word_ptr <= r_word_ptr + ROM_ADDR_WIDTH'(1);
                        if (r_remaining == 8'd0) begin
                            r_state <= StFlush;
                        end else begin
                            r_remaining <= r_remaining - 8'd1;
                        end
                    end
                end
                StFlush: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                    end else begin
                        r_end   <= 1'b1;
                        r_state <= StEnd;
                    end
                end
                StEnd:   r_state <= StIdle;
                StError: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign addressDataOut    = r_data;
    assign dataValidOut      = r_valid;
    assign endTransactionOut = r_end;
    assign busErrorOut       = r_err;
    assign busyOut           = 1'b0;

endmodule

// File: tb/tb_bios_rom_bus_slave.sv
// Directed bench for bios_rom_bus_slave: a cycle-indexed expectation schedule built
// from the transaction rules, checked every cycle, plus hand-computed literal checks.
module tb_bios_rom_bus_slave;

    localparam int MAXC = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [7:0]  burstSizeIn;
    logic [3:0]  byteEnablesIn;
    logic        endTransactionIn;
    logic        busErrorIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;
    logic        busyOut;
    logic [10:0] romAddress;
    logic [31:0] romData;

    logic [31:0] rom [0:2047];

    bios_rom_bus_slave dut (
        .clock             (clock),
        .reset             (reset),
        .beginTransactionIn(beginTransactionIn),
        .addressDataIn     (addressDataIn),
        .readNotWriteIn    (readNotWriteIn),
        .burstSizeIn       (burstSizeIn),
        .byteEnablesIn     (byteEnablesIn),
        .endTransactionIn  (endTransactionIn),
        .busErrorIn        (busErrorIn),
        .addressDataOut    (addressDataOut),
        .dataValidOut      (dataValidOut),
        .endTransactionOut (endTransactionOut),
        .busErrorOut       (busErrorOut),
        .busyOut           (busyOut),
        .romAddress        (romAddress),
        .romData           (romData)
    );

    assign romData = rom[romAddress];

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected bus state for each cycle; zero means "slave silent".
    logic        exp_v   [0:MAXC-1];
    logic [31:0] exp_d   [0:MAXC-1];
    logic        exp_e   [0:MAXC-1];
    logic        exp_err [0:MAXC-1];
    logic        exp_ra_v[0:MAXC-1];
    logic [10:0] exp_ra  [0:MAXC-1];

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic logic [31:0] swap_model(input logic [31:0] d);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(3-b) +: 8];
        return r;
    endfunction

    // A transaction presented in cycle t: reads produce words at t+2.., the end pulse
    // one cycle after the last word; writes to the window produce error+end at t+2.
    task automatic model_txn(input int t, input logic [31:0] addr, input logic rnw,
                             input logic [7:0] burst);
        int n;
        int w;
        if ((addr >> 13) != (32'hF000_0000 >> 13)) return;
        if (!rnw) begin
            exp_err[t+2] = 1'b1;
            exp_e[t+2]   = 1'b1;
            return;
        end
        n = int'(burst) + 1;
        w = int'(addr[12:2]);
        for (int k = 0; k < n; k++) begin
            exp_ra_v[t+1+k] = 1'b1;
            exp_ra[t+1+k]   = 11'((w + k) % 2048);
            exp_v[t+2+k]    = 1'b1;
            exp_d[t+2+k]    = swap_model(rom[(w + k) % 2048]);
        end
        exp_e[t+n+2] = 1'b1;
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            exp_v[i] = 1'b0; exp_d[i] = '0; exp_e[i] = 1'b0;
            exp_err[i] = 1'b0; exp_ra_v[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) step();
        #3;
    endtask

    task automatic issue(input logic [31:0] addr, input logic rnw, input logic [7:0] burst,
                         output int t);
        t = cyc;
        beginTransactionIn = 1'b1;
        addressDataIn      = addr;
        readNotWriteIn     = rnw;
        burstSizeIn        = burst;
        byteEnablesIn      = 4'($urandom);
        model_txn(t, addr, rnw, burst);
        step();
        beginTransactionIn = 1'b0;
        addressDataIn      = $urandom;
        readNotWriteIn     = 1'($urandom);
        burstSizeIn        = 8'($urandom);
    endtask

    // Abort raised in cycle a is seen by the FSM at a+1, so the bus goes quiet from a+2.
    task automatic abort_pulse(input bit use_err);
        int a;
        a = cyc;
        if (use_err) busErrorIn = 1'b1;
        else endTransactionIn = 1'b1;
        clear_from(a + 2);
        step();
        busErrorIn       = 1'b0;
        endTransactionIn = 1'b0;
    endtask

    task automatic reset_pulse();
        int r;
        r = cyc;
        reset = 1'b1;
        clear_from(r + 1);
        exp_ra_v[r+1] = 1'b1;
        exp_ra[r+1]   = '0;
        step();
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (check_en && cyc < MAXC) begin
            chk("dataValidOut", 32'(dataValidOut), 32'(exp_v[cyc]));
            chk("addressDataOut", addressDataOut, exp_d[cyc]);
            chk("endTransactionOut", 32'(endTransactionOut), 32'(exp_e[cyc]));
            chk("busErrorOut", 32'(busErrorOut), 32'(exp_err[cyc]));
            chk("busyOut", 32'(busyOut), 32'd0);
            if (exp_ra_v[cyc]) chk("romAddress", 32'(romAddress), 32'(exp_ra[cyc]));
        end
    end

    initial begin
        int t;
        for (int i = 0; i < 2048; i++) rom[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5C3_0000;
        rom[0]    = 32'hEFBE_ADDE;
        rom[1]    = 32'h0000_0015;
        rom[2]    = 32'h1100_0000;
        rom[3]    = 32'h0000_0015;
        rom[4]    = 32'h0F00_0000;
        rom[2047] = 32'h1122_3344;
        clear_from(0);
        reset = 1'b1;
        beginTransactionIn = 1'b0;
        addressDataIn = '0;
        readNotWriteIn = 1'b0;
        burstSizeIn = '0;
        byteEnablesIn = '0;
        endTransactionIn = 1'b0;
        busErrorIn = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_ra_v[cyc] = 1'b1;
        exp_ra[cyc]   = '0;
        check_en = 1'b1;
        goto_cyc(cyc);
        chk("reset_romAddress", 32'(romAddress), 32'd0);
        chk("reset_valid", 32'(dataValidOut), 32'd0);
        step();
        step();

        // Single read
        issue(32'hF000_0000, 1'b1, 8'd0, t);
        goto_cyc(t + 2);
        chk("t1_data", addressDataOut, 32'hDEAD_BEEF);
        chk("t1_valid", 32'(dataValidOut), 32'd1);
        goto_cyc(t + 3);
        chk("t1_end", 32'(endTransactionOut), 32'd1);
        chk("t1_valid_off", 32'(dataValidOut), 32'd0);
        step();
        step();

        // Four-word burst
        issue(32'hF000_0004, 1'b1, 8'd3, t);
        goto_cyc(t + 2); chk("t2_w0", addressDataOut, 32'h1500_0000);
        goto_cyc(t + 3); chk("t2_w1", addressDataOut, 32'h0000_0011);
        goto_cyc(t + 4); chk("t2_w2", addressDataOut, 32'h1500_0000);
        goto_cyc(t + 5); chk("t2_w3", addressDataOut, 32'h0000_000F);
        goto_cyc(t + 6); chk("t2_end", 32'(endTransactionOut), 32'd1);
        step();

        // Write to the window
        issue(32'hF000_0010, 1'b0, 8'd0, t);
        goto_cyc(t + 2);
        chk("t3_err", 32'(busErrorOut), 32'd1);
        chk("t3_end", 32'(endTransactionOut), 32'd1);
        goto_cyc(t + 3);
        chk("t3_err_off", 32'(busErrorOut), 32'd0);
        step();

        // Miss: schedule stays silent
        issue(32'h5000_0000, 1'b1, 8'd2, t);
        for (int i = 0; i < 10; i++) step();

        // Wrap from the last word to word 0
        issue(32'hF000_1FFC, 1'b1, 8'd1, t);
        goto_cyc(t + 1); chk("t5_ra_last", 32'(romAddress), 32'd2047);
        goto_cyc(t + 2);
        chk("t5_ra_wrap", 32'(romAddress), 32'd0);
        chk("t5_w0", addressDataOut, 32'h4433_2211);
        goto_cyc(t + 3); chk("t5_w1", addressDataOut, 32'hDEAD_BEEF);
        step();
        step();

        // Reset during the second word, then a clean read
        issue(32'hF000_0004, 1'b1, 8'd3, t);
        step();
        step();
        reset_pulse();
        goto_cyc(t + 4);
        chk("t6_rst_valid", 32'(dataValidOut), 32'd0);
        chk("t6_rst_data", addressDataOut, 32'd0);
        step();
        issue(32'hF000_0008, 1'b1, 8'd1, t);
        goto_cyc(t + 2); chk("t6_after_w0", addressDataOut, 32'h0000_0011);
        goto_cyc(t + 4); chk("t6_after_end", 32'(endTransactionOut), 32'd1);
        step();

        // Master abort mid-burst
        issue(32'hF000_0004, 1'b1, 8'd3, t);
        step();
        abort_pulse(1'b0);
        goto_cyc(t + 3); chk("t6_abort_w1", 32'(dataValidOut), 32'd1);
        goto_cyc(t + 4); chk("t6_abort_off", 32'(dataValidOut), 32'd0);
        goto_cyc(t + 6); chk("t6_abort_noend", 32'(endTransactionOut), 32'd0);
        step();

        // Foreign bus error while flushing the last word
        issue(32'hF000_0000, 1'b1, 8'd2, t);
        step();
        step();
        abort_pulse(1'b1);
        goto_cyc(t + 4); chk("t6_berr_last", 32'(dataValidOut), 32'd1);
        goto_cyc(t + 5); chk("t6_berr_noend", 32'(endTransactionOut), 32'd0);
        for (int i = 0; i < 4; i++) step();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
